mips_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the 32-bit MIPS core.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, register file, sign extender and unified memory port.
- Configures the sign extender per opcode: sign-extend for arithmetic, load/store and branch immediates; zero-extend for logical immediates.
- Owns the memory request/ready handshake, including a timeout.

---
 rtl/mips_ctrl_pkg.sv | 51 +++++
 rtl/mips_multicycle_ctrl_if.sv | 12 +
 rtl/mips_mem_handshake.sv | 33 +++
 rtl/mips_multicycle_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
// Latency: none, constants and types only.
// Backpressure: none.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_EXEC_I    = 4'd7,
    ST_ALU_WB    = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_IMM   = 2'd3;

  // Logical immediates take a zero-extended operand; everything else sign-extends.
  function automatic logic zero_ext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Unified memory port between the control FSM and the memory system.
// Latency: none, wiring only.
// Backpressure: mem_ready from the memory side stretches any request.
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mips_mem_handshake.sv
// Wait counter and completion/timeout qualification for one memory access.
// Latency: done/timeout are combinational in the request cycle.
// Backpressure: counts mem_ready=0 cycles; flags timeout after MEM_TIMEOUT of them.
module mips_mem_handshake #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  output logic done,
  output logic timeout
);

  logic [CNT_W-1:0] cnt;
  logic             expired;

  assign expired = (cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign done    = req & ready;
  assign timeout = req & ~ready & expired;

  // Every memory state is entered after a non-request cycle, a completion or a
  // timeout, so clearing on those events clears on every entry.
  always_ff @(posedge clk) begin
    if (!rst_n || !req || ready || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency: lw 5, sw/R/I 4, branch/jump 3, illegal 2 cycles with memory ready.
// Backpressure: memory states hold until mem_ready or MEM_TIMEOUT expires.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [5:0]                  opcode,
  input  logic                        zero,
  mips_multicycle_ctrl_if.master      mem,
  output logic                        ir_write,
  output logic                        pc_write,
  output logic [1:0]                  pc_src,
  output logic                        alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [1:0]                  alu_op,
  output logic                        ext_mode,
  output logic                        reg_write,
  output logic                        reg_dst,
  output logic                        mem_to_reg,
  output logic                        instr_done,
  output logic                        illegal_op,
  output logic                        bus_error,
  output logic [3:0]                  state_dbg
);

  state_t     state, state_next;
  logic       req_c, we_c, iord_c;
  logic       acc_done, acc_timeout;
  logic       ir_write_c, pc_write_c, alu_src_a_c, ext_mode_c;
  logic       reg_write_c, reg_dst_c, mem_to_reg_c, instr_done_c, illegal_op_c;
  logic [1:0] pc_src_c, alu_src_b_c, alu_op_c;

  // Memory strobes depend on state only, so the handshake sees no input path.
  assign req_c  = (state == ST_FETCH) || (state == ST_MEM_READ) || (state == ST_MEM_WRITE);
  assign we_c   = (state == ST_MEM_WRITE);
  assign iord_c = (state == ST_MEM_READ) || (state == ST_MEM_WRITE);

  mips_mem_handshake #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_hs (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (mem.mem_req),
    .ready   (mem.mem_ready),
    .done    (acc_done),
    .timeout (acc_timeout)
  );

  // State register; reset returns to FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next   = state;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = PCSRC_ALU;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = SRCB_RT;
    alu_op_c     = ALUOP_ADD;
    ext_mode_c   = 1'b0;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    instr_done_c = 1'b0;
    illegal_op_c = 1'b0;
    case (state)
      ST_FETCH: begin
        alu_src_b_c = SRCB_FOUR;
        if (acc_done) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b_c = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW:                            state_next = ST_MEM_ADDR;
          OP_R:                                    state_next = ST_EXEC_R;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: state_next = ST_EXEC_I;
          OP_BEQ, OP_BNE:                          state_next = ST_BRANCH;
          OP_J:                                    state_next = ST_JUMP;
          default: begin
            illegal_op_c = 1'b1;
            instr_done_c = 1'b1;
            state_next   = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        state_next  = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        if (acc_done)         state_next = ST_MEM_WB;
        else if (acc_timeout) state_next = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        if (acc_done) begin
          instr_done_c = 1'b1;
          state_next   = ST_FETCH;
        end else if (acc_timeout) begin
          state_next = ST_FETCH;
        end
      end
      ST_MEM_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        instr_done_c = 1'b1;
        state_next   = ST_FETCH;
      end
      ST_EXEC_R: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALUOP_FUNCT;
        reg_dst_c   = 1'b1;
        state_next  = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        alu_op_c    = ALUOP_IMM;
        ext_mode_c  = zero_ext_op(opcode);
        state_next  = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = (opcode == OP_R);
        instr_done_c = 1'b1;
        state_next   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a_c  = 1'b1;
        alu_op_c     = ALUOP_SUB;
        pc_src_c     = PCSRC_ALUOUT;
        pc_write_c   = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
        instr_done_c = 1'b1;
        state_next   = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src_c     = PCSRC_JUMP;
        pc_write_c   = 1'b1;
        instr_done_c = 1'b1;
        state_next   = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
    if (acc_timeout) state_next = ST_FETCH;
  end

  // Reset forces every output low immediately, abandoning any in-flight access.
  assign mem.mem_req  = rst_n & req_c;
  assign mem.mem_we   = rst_n & we_c;
  assign mem.iord     = rst_n & iord_c;
  assign ir_write     = rst_n & ir_write_c;
  assign pc_write     = rst_n & pc_write_c;
  assign pc_src       = rst_n ? pc_src_c : 2'd0;
  assign alu_src_a    = rst_n & alu_src_a_c;
  assign alu_src_b    = rst_n ? alu_src_b_c : 2'd0;
  assign alu_op       = rst_n ? alu_op_c : 2'd0;
  assign ext_mode     = rst_n & ext_mode_c;
  assign reg_write    = rst_n & reg_write_c;
  assign reg_dst      = rst_n & reg_dst_c;
  assign mem_to_reg   = rst_n & mem_to_reg_c;
  assign instr_done   = rst_n & instr_done_c;
  assign illegal_op   = rst_n & illegal_op_c;
  assign bus_error    = rst_n & acc_timeout;
  assign state_dbg    = rst_n ? state : 4'd0;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for the multi-cycle MIPS control FSM.
// Stimulus walks instruction paths derived from opcode; monitor checks every cycle.
// Memory readiness is randomized, with directed stalls, timeouts and resets.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       ir_write, pc_write, alu_src_a, ext_mode, reg_write, reg_dst;
  logic       mem_to_reg, instr_done, illegal_op, bus_error;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state_dbg;

  mips_multicycle_ctrl_if mem ();

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem        (mem),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .ext_mode   (ext_mode),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .bus_error  (bus_error),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       ext_mode, reg_write, reg_dst, mem_to_reg, instr_done, illegal_op, bus_error;
    logic [3:0] st;
  } ctl_t;

  typedef struct {
    ctl_t  v;
    string tag;
  } exp_t;

  exp_t       sb[$];
  state_t     path_q[$];
  int         total = 0;
  int         bad = 0;
  logic [5:0] legal_ops [11] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                 6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001111,
                                 6'b000010};

  // Control word each step presents before any input qualification.
  function automatic ctl_t base(input state_t s, input logic [5:0] op);
    ctl_t c = '0;
    c.st = s;
    case (s)
      ST_FETCH:     begin c.mem_req = 1; c.alu_src_b = 2'd1; end
      ST_DECODE:    c.alu_src_b = 2'd3;
      ST_MEM_ADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
      ST_MEM_READ:  begin c.mem_req = 1; c.iord = 1; end
      ST_MEM_WRITE: begin c.mem_req = 1; c.mem_we = 1; c.iord = 1; end
      ST_MEM_WB:    begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
      ST_EXEC_R:    begin c.alu_src_a = 1; c.alu_op = 2'd2; c.reg_dst = 1; end
      ST_EXEC_I: begin
        c.alu_src_a = 1; c.alu_src_b = 2'd2; c.alu_op = 2'd3;
        c.ext_mode  = (op == 6'b001100) || (op == 6'b001101);
      end
      ST_ALU_WB: begin
        c.reg_write = 1; c.reg_dst = (op == 6'b000000); c.instr_done = 1;
      end
      ST_BRANCH:    begin c.alu_src_a = 1; c.alu_op = 2'd1; c.pc_src = 2'd1; c.instr_done = 1; end
      ST_JUMP:      begin c.pc_src = 2'd2; c.pc_write = 1; c.instr_done = 1; end
      default:      c = '0;
    endcase
    return c;
  endfunction

  // Sequence of steps an instruction visits, from its opcode class.
  task automatic build_path(input logic [5:0] op);
    path_q.delete();
    path_q.push_back(ST_FETCH);
    path_q.push_back(ST_DECODE);
    case (op)
      6'b100011: begin path_q.push_back(ST_MEM_ADDR); path_q.push_back(ST_MEM_READ);
                       path_q.push_back(ST_MEM_WB); end
      6'b101011: begin path_q.push_back(ST_MEM_ADDR); path_q.push_back(ST_MEM_WRITE); end
      6'b000000: begin path_q.push_back(ST_EXEC_R); path_q.push_back(ST_ALU_WB); end
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001111:
                 begin path_q.push_back(ST_EXEC_I); path_q.push_back(ST_ALU_WB); end
      6'b000100, 6'b000101: path_q.push_back(ST_BRANCH);
      6'b000010: path_q.push_back(ST_JUMP);
      default: ;
    endcase
  endtask

  task automatic drive(input ctl_t v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_hold(input int k);
    ctl_t z = '0;
    rst_n = 1'b0;
    for (int i = 0; i < k; i++) begin
      mem.mem_ready = 1'($urandom_range(1));
      opcode        = 6'($urandom_range(63));
      drive(z, "reset");
    end
    rst_n = 1'b1;
  endtask

  // Runs one instruction; stuck_st holds mem_ready low in that step, min_lows
  // forces that many low cycles at the start of every memory step, and
  // rst_after (>=0) pulls reset once that many cycles have elapsed.
  task automatic run_instr(input logic [5:0] op, input int rdy_pct, input int stuck_st,
                           input int min_lows, input logic zf, input int rst_after,
                           input string name);
    int   n = 0;
    int   waits;
    bit   legal, is_mem, rdy, tmo;
    ctl_t c;
    build_path(op);
    legal  = (path_q.size() > 2);
    opcode = op;
    zero   = zf;
    foreach (path_q[i]) begin
      waits = 0;
      forever begin
        if (n == rst_after) begin
          reset_hold(3);
          return;
        end
        c      = base(path_q[i], op);
        is_mem = c.mem_req;
        if (!is_mem)                           rdy = 1'($urandom_range(1));
        else if (int'(path_q[i]) == stuck_st)  rdy = 1'b0;
        else if (waits < min_lows)             rdy = 1'b0;
        else                                   rdy = ($urandom_range(99) < rdy_pct);
        mem.mem_ready = rdy;
        if (path_q[i] == ST_DECODE && !legal) begin c.illegal_op = 1; c.instr_done = 1; end
        if (path_q[i] == ST_BRANCH) c.pc_write = (op == 6'b000100) ? zf : ~zf;
        if (is_mem && rdy) begin
          if (path_q[i] == ST_FETCH)     begin c.ir_write = 1; c.pc_write = 1; end
          if (path_q[i] == ST_MEM_WRITE) c.instr_done = 1;
        end
        tmo = 1'b0;
        if (is_mem && !rdy) begin
          waits++;
          if (waits == TMO) begin c.bus_error = 1; tmo = 1'b1; end
        end
        drive(c, $sformatf("%s/st%0d", name, c.st));
        n++;
        if (tmo) return;
        if (!is_mem || rdy) break;
      end
    end
  endtask

  // Monitor: compares the DUT against the oldest expectation each cycle.
  always @(negedge clk) begin
    exp_t e;
    ctl_t act;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act = '{mem.mem_req, mem.mem_we, mem.iord, ir_write, pc_write, pc_src, alu_src_a,
              alu_src_b, alu_op, ext_mode, reg_write, reg_dst, mem_to_reg, instr_done,
              illegal_op, bus_error, state_dbg};
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s: got ctl=%h required ctl=%h (t=%0t)", e.tag, act, e.v, $time);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    rst_n         = 1'b0;
    opcode        = 6'd0;
    zero          = 1'b0;
    mem.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_hold(2);
    run_instr(6'b100011, 100, -1, 0, 1'b0, -1, "lw");
    run_instr(6'b000100, 100, -1, 0, 1'b1, -1, "beq_z1");
    run_instr(6'b000100, 100, -1, 0, 1'b0, -1, "beq_z0");
    run_instr(6'b000101, 100, -1, 0, 1'b0, -1, "bne_z0");
    run_instr(6'b000101, 100, -1, 0, 1'b1, -1, "bne_z1");
    run_instr(6'b000010, 100, -1, 0, 1'b0, -1, "j");
    run_instr(6'b001100, 100, -1, 0, 1'b0, -1, "andi");
    run_instr(6'b001000, 100, -1, 0, 1'b0, -1, "addi");
    run_instr(6'b001101, 100, -1, 0, 1'b0, -1, "ori");
    run_instr(6'b001010, 100, -1, 0, 1'b0, -1, "slti");
    run_instr(6'b001111, 100, -1, 0, 1'b0, -1, "lui");
    run_instr(6'b000000, 100, -1, 0, 1'b0, -1, "rtype");
    run_instr(6'b101011, 100, -1, 0, 1'b0, -1, "sw");
    run_instr(6'b001000, 100, int'(ST_FETCH) + 100, 3, 1'b0, -1, "fetch_stall");
    run_instr(6'b100011, 100, int'(ST_MEM_READ), 0, 1'b0, -1, "lw_timeout");
    run_instr(6'b001000, 100, -1, 0, 1'b0, -1, "after_tmo");
    run_instr(6'b111111, 100, -1, 0, 1'b0, -1, "illegal");
    run_instr(6'b001000, 100, int'(ST_FETCH), 0, 1'b0, -1, "fetch_timeout");
    run_instr(6'b101011, 100, -1, 2, 1'b0, 6, "sw_reset");
    run_instr(6'b000000, 100, -1, 0, 1'b0, -1, "after_rst");
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(4) == 0) op = 6'($urandom_range(63));
      else                        op = legal_ops[$urandom_range(10)];
      run_instr(op, int'($urandom_range(100, 60)),
                ($urandom_range(19) == 0) ? int'(ST_MEM_READ) + 2 * int'($urandom_range(1))
                                          : -1,
                0, 1'($urandom_range(1)), -1, $sformatf("rnd%0d", k));
    end
    repeat (3) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
